// File: rtl/obst_pkg.sv
// Shared types, default screen geometry and helper functions
// for the multi-obstacle controller.
package obst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_H_MAX     = 800;
    localparam int DEF_V_MAX     = 600;
    localparam int DEF_OBST_SIZE = 32;

    // Evenly spaced start position along one axis
    function automatic int init_pos(
        input int i,
        input int max,
        input int size,
        input int n
    );
        return (i + 1) * (max - size) / (n + 1);
    endfunction

    function automatic logic overlap(
        input logic [31:0] ax,
        input logic [31:0] ay,
        input logic [31:0] bx,
        input logic [31:0] by,
        input int          size
    );
        logic [31:0] dx;
        logic [31:0] dy;
        dx = (ax > bx) ? (ax - bx) : (bx - ax);
        dy = (ay > by) ? (ay - by) : (by - ay);
        return (dx < 32'(size)) && (dy < 32'(size));
    endfunction

endpackage

// File: rtl/obst_axis_step.sv
// One-axis bounce step: advance a coordinate by STEP and
// reflect off 0 / MAX-OBST_SIZE.
module obst_axis_step #(
    parameter int POS_W     = 12,
    parameter int OBST_SIZE = 32,
    parameter int STEP      = 2
) (
    input  logic [POS_W-1:0] pos,
    input  logic             dir,
    input  logic [POS_W-1:0] max,
    output logic [POS_W-1:0] next_pos,
    output logic             next_dir
);

    logic [POS_W:0] w_sum;
    logic [POS_W:0] w_lim;
    logic [POS_W:0] w_pos_ext;

    assign w_pos_ext = {1'b0, pos};
    assign w_sum     = w_pos_ext + (POS_W+1)'(STEP);
    assign w_lim     = {1'b0, max} - (POS_W+1)'(OBST_SIZE);

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        if (dir) begin
            if (w_sum > w_lim) begin
                next_pos = w_lim[POS_W-1:0];
                next_dir = 1'b0;
            end else begin
                next_pos = w_sum[POS_W-1:0];
            end
        end else begin
            if (w_pos_ext < (POS_W+1)'(STEP)) begin
                next_pos = '0;
                next_dir = 1'b1;
            end else begin
                next_pos = pos - POS_W'(STEP);
            end
        end
    end

endmodule

// File: rtl/multi_obst_ctl.sv
// Multi-channel bouncing obstacle controller, one channel per sweep cycle.
// Optional user/obstacle hit detection with MULTI_OBST_COLLISION_EN.
module multi_obst_ctl
    import obst_pkg::*;
#(
    parameter int N_OBST    = 4,
    parameter int POS_W     = 12,
    parameter int H_MAX     = DEF_H_MAX,
    parameter int V_MAX     = DEF_V_MAX,
    parameter int OBST_SIZE = DEF_OBST_SIZE,
    parameter int STEP      = 2
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    enable,
    input  logic [N_OBST-1:0]       mode,
    input  logic [POS_W-1:0]        user_xpos,
    input  logic [POS_W-1:0]        user_ypos,
    input  logic                    hit_clr,
    output logic [N_OBST*POS_W-1:0] xpos,
    output logic [N_OBST*POS_W-1:0] ypos,
    output logic                    busy,
    output logic                    hit
);

    localparam int IDX_W = (N_OBST > 1) ? $clog2(N_OBST) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [POS_W-1:0]   r_x [N_OBST];
    logic [POS_W-1:0]   r_y [N_OBST];
    logic [N_OBST-1:0]  r_dir;

    logic               w_last;
    logic               w_mode;
    logic [POS_W-1:0]   w_pos;
    logic [POS_W-1:0]   w_max;
    logic [POS_W-1:0]   w_npos;
    logic               w_ndir;

    assign w_last = (r_idx == IDX_W'(N_OBST - 1));
    assign w_mode = mode[r_idx];
    assign w_pos  = w_mode ? r_y[r_idx] : r_x[r_idx];
    assign w_max  = w_mode ? POS_W'(V_MAX) : POS_W'(H_MAX);

    obst_axis_step #(
        .POS_W     (POS_W),
        .OBST_SIZE (OBST_SIZE),
        .STEP      (STEP)
    ) u_step (
        .pos      (w_pos),
        .dir      (r_dir[r_idx]),
        .max      (w_max),
        .next_pos (w_npos),
        .next_dir (w_ndir)
    );

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (tick && enable) w_next = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == SWEEP) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Only the channel selected by r_idx moves, on its own axis
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OBST; i++) begin
                r_x[i] <= POS_W'(init_pos(i, H_MAX, OBST_SIZE, N_OBST));
                r_y[i] <= POS_W'(init_pos(i, V_MAX, OBST_SIZE, N_OBST));
            end
            r_dir <= '1;
        end else if (r_state == SWEEP) begin
            r_dir[r_idx] <= w_ndir;
            if (w_mode) r_y[r_idx] <= w_npos;
            else        r_x[r_idx] <= w_npos;
        end
    end

    for (genvar g = 0; g < N_OBST; g++) begin : g_out
        assign xpos[g*POS_W +: POS_W] = r_x[g];
        assign ypos[g*POS_W +: POS_W] = r_y[g];
    end

`ifdef MULTI_OBST_COLLISION_EN
    logic [POS_W-1:0] w_new_x;
    logic [POS_W-1:0] w_new_y;
    logic             w_ovl;
    logic             r_hit;

    assign w_new_x = w_mode ? r_x[r_idx] : w_npos;
    assign w_new_y = w_mode ? w_npos : r_y[r_idx];
    assign w_ovl   = overlap(32'(w_new_x), 32'(w_new_y),
                             32'(user_xpos), 32'(user_ypos), OBST_SIZE);

    // A new overlap outranks a clear in the same cycle
    always_ff @(posedge pclk or posedge rst) begin
        if (rst)                              r_hit <= 1'b0;
        else if ((r_state == SWEEP) && w_ovl) r_hit <= 1'b1;
        else if (hit_clr)                     r_hit <= 1'b0;
    end

    assign hit = r_hit;
`else
    logic w_unused;
    assign w_unused = ^{user_xpos, user_ypos, hit_clr};
    assign hit      = 1'b0;
`endif

endmodule

// File: tb/tb_multi_obst_ctl.sv
// Directed bench for multi_obst_ctl with default parameters.
module tb_multi_obst_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        tick;
    logic        enable;
    logic [3:0]  mode;
    logic [11:0] ux;
    logic [11:0] uy;
    logic        hit_clr;
    logic [47:0] xpos;
    logic [47:0] ypos;
    logic        busy;
    logic        hit;

    int nvec = 0;
    int nerr = 0;
    logic exp_hit;

    always #5 pclk = ~pclk;

    multi_obst_ctl dut (
        .pclk      (pclk),
        .rst       (rst),
        .tick      (tick),
        .enable    (enable),
        .mode      (mode),
        .user_xpos (ux),
        .user_ypos (uy),
        .hit_clr   (hit_clr),
        .xpos      (xpos),
        .ypos      (ypos),
        .busy      (busy),
        .hit       (hit)
    );

    function automatic logic [11:0] gx(input int i);
        return xpos[i*12 +: 12];
    endfunction

    function automatic logic [11:0] gy(input int i);
        return ypos[i*12 +: 12];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic sweep(input bit drop_en);
        tick = 1'b1;
        tk(1);
        tick = 1'b0;
        if (drop_en) enable = 1'b0;
        tk(5);
        enable = 1'b1;
    endtask

    initial begin
`ifdef MULTI_OBST_COLLISION_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        rst = 1'b1; tick = 1'b0; enable = 1'b1; mode = 4'h0;
        ux = '0; uy = '0; hit_clr = 1'b0;
        tk(2);
        chk("rst_x0", gx(0), 153);
        chk("rst_y0", gy(0), 113);
        chk("rst_x1", gx(1), 307);
        chk("rst_x3", gx(3), 614);
        chk("rst_y3", gy(3), 454);
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        rst = 1'b0;
        tk(1);

        tick = 1'b1;
        tk(1);
        tick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("busy_sweep", busy, 1);
            tk(1);
        end
        chk("busy_end", busy, 0);
        chk("s1_x0", gx(0), 155);
        chk("s1_x1", gx(1), 309);
        chk("s1_x2", gx(2), 462);
        chk("s1_x3", gx(3), 616);
        chk("s1_y0", gy(0), 113);
        chk("s1_y2", gy(2), 340);

        tick = 1'b1;
        tk(6);
        tick = 1'b0;
        tk(1);
        chk("drop_busy", busy, 0);
        chk("drop_x0", gx(0), 157);
        chk("drop_x3", gx(3), 618);

        enable = 1'b0;
        tick = 1'b1;
        tk(1);
        tick = 1'b0;
        enable = 1'b1;
        chk("dis_busy", busy, 0);
        tk(2);
        chk("dis_x0", gx(0), 157);

        for (int k = 0; k < 305; k++) sweep(1'b0);
        chk("clamp_pre_x0", gx(0), 767);
        chk("clamp_pre_x3", gx(3), 310);
        sweep(1'b0);
        chk("clamp_x0", gx(0), 768);
        chk("clamp_x3", gx(3), 308);
        sweep(1'b0);
        chk("bounce_x0", gx(0), 766);
        chk("bounce_x3", gx(3), 306);
        chk("bounce_y0", gy(0), 113);

        tick = 1'b1;
        tk(1);
        tick = 1'b0;
        tk(1);
        chk("mid_x0", gx(0), 764);
        rst = 1'b1;
        #1;
        chk("mrst_x0", gx(0), 153);
        chk("mrst_y0", gy(0), 113);
        chk("mrst_x1", gx(1), 307);
        chk("mrst_busy", busy, 0);
        chk("mrst_hit", hit, 0);
        tk(1);
        rst = 1'b0;
        tk(1);
        chk("mrst_idle", busy, 0);

        mode = 4'hF;
        for (int k = 0; k < 57; k++) sweep(1'b0);
        chk("v_pre_y3", gy(3), 568);
        chk("v_pre_x3", gx(3), 614);
        chk("v_pre_y0", gy(0), 227);
        chk("v_pre_x0", gx(0), 153);
        sweep(1'b0);
        chk("v_clamp_y3", gy(3), 568);
        sweep(1'b1);
        chk("v_bounce_y3", gy(3), 566);
        chk("v_en_drop_y0", gy(0), 231);
        chk("v_en_drop_busy", busy, 0);
        chk("v_pre_hit", hit, 0);

        ux = 12'd460;
        uy = 12'd460;
        sweep(1'b0);
        chk("col_y2", gy(2), 460);
        chk("col_x2", gx(2), 460);
        chk("col_hit", hit, 32'(exp_hit));
        tk(3);
        chk("col_sticky", hit, 32'(exp_hit));
        hit_clr = 1'b1;
        tk(1);
        hit_clr = 1'b0;
        chk("col_clr", hit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
